// File: rtl/pz_loader.sv
// Pole/zero register-file loader: decodes a header beat, streams coefficients into
// the register file, then holds the accumulator enabled through its pipeline flush.

module pz_entry #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 we,
  input  logic [DATA_SIZE-1:0] d,
  output logic [DATA_SIZE-1:0] q
);
  logic [DATA_SIZE-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)     q_d = '0;
    else if (we) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

module pz_loader #(
  parameter int REG_FILE_SIZE = 8,
  parameter int DATA_SIZE     = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_valid,
  input  logic [DATA_SIZE-1:0]               s_data,
  output logic                               s_ready,
  output logic [DATA_SIZE*REG_FILE_SIZE-1:0] flat_pz,
  output logic [31:0]                        no_z,
  output logic [31:0]                        no_p,
  output logic                               acc_ready,
  output logic                               acc_valid,
  output logic                               hdr_err
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  no_z_q, no_z_d, no_p_q, no_p_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;
  logic        s_ready_q, s_ready_d;
  logic        acc_ready_q, acc_ready_d;
  logic        acc_valid_q, acc_valid_d;
  logic        hdr_err_q, hdr_err_d;
  logic        clr_all, wr_en, fire;
  logic [3:0]  hdr_nz, hdr_np;
  logic [4:0]  hdr_sum, total;
  logic        hdr_legal, load_last;

  assign fire      = s_valid & s_ready_q;
  assign hdr_nz    = s_data[3:0];
  assign hdr_np    = s_data[7:4];
  assign hdr_sum   = {1'b0, hdr_nz} + {1'b0, hdr_np};
  assign hdr_legal = (32'(hdr_sum) <= 32'(REG_FILE_SIZE));
  assign total     = {1'b0, no_z_q} + {1'b0, no_p_q};
  assign load_last = (idx_q == total - 5'd1);

  always_comb begin
    state_d     = state_q;
    no_z_d      = no_z_q;
    no_p_d      = no_p_q;
    idx_d       = idx_q;
    flush_cnt_d = flush_cnt_q;
    hdr_err_d   = 1'b0;
    clr_all     = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        // Every accepted beat outside LOAD is a header.
        if (fire) begin
          if (hdr_legal) begin
            clr_all     = 1'b1;
            no_z_d      = hdr_nz;
            no_p_d      = hdr_np;
            idx_d       = '0;
            flush_cnt_d = '0;
            state_d     = (hdr_sum == 5'd0) ? FLUSH : LOAD;
          end else begin
            hdr_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (fire) begin
          wr_en = 1'b1;
          idx_d = idx_q + 5'd1;
          if (load_last) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 2'd1;
        if (flush_cnt_q == 2'd2) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so they are decoded from the next state.
    s_ready_d   = (state_d != FLUSH);
    acc_ready_d = (state_d == FLUSH) || (state_d == RUN);
    acc_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      no_z_q      <= '0;
      no_p_q      <= '0;
      idx_q       <= '0;
      flush_cnt_q <= '0;
      s_ready_q   <= 1'b0;
      acc_ready_q <= 1'b0;
      acc_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      no_z_q      <= no_z_d;
      no_p_q      <= no_p_d;
      idx_q       <= idx_d;
      flush_cnt_q <= flush_cnt_d;
      s_ready_q   <= s_ready_d;
      acc_ready_q <= acc_ready_d;
      acc_valid_q <= acc_valid_d;
      hdr_err_q   <= hdr_err_d;
    end
  end

  logic [REG_FILE_SIZE-1:0][DATA_SIZE-1:0] entry_q;

  for (genvar i = 0; i < REG_FILE_SIZE; i++) begin : g_entry
    pz_entry #(.DATA_SIZE(DATA_SIZE)) u_entry (
      .clk (clk),
      .rst (rst),
      .clr (clr_all),
      .we  (wr_en && (32'(idx_q) == i)),
      .d   (s_data),
      .q   (entry_q[i])
    );
  end

  assign flat_pz   = entry_q;
  assign no_z      = {28'd0, no_z_q};
  assign no_p      = {28'd0, no_p_q};
  assign s_ready   = s_ready_q;
  assign acc_ready = acc_ready_q;
  assign acc_valid = acc_valid_q;
  assign hdr_err   = hdr_err_q;
endmodule

// File: tb/tb_pz_loader.sv
// Directed bench for pz_loader with a behavioural accumulator on flat_pz/no_z/no_p.

module tb_pz_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [63:0] flat_pz;
  logic [31:0] no_z, no_p;
  logic        acc_ready, acc_valid, hdr_err;
  int          checks = 0;
  int          errors = 0;

  pz_loader #(.REG_FILE_SIZE(8), .DATA_SIZE(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .flat_pz(flat_pz), .no_z(no_z), .no_p(no_p),
    .acc_ready(acc_ready), .acc_valid(acc_valid), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream accumulator: zeros minus poles, modulo 2^8.
  function automatic logic [7:0] acc_pz();
    logic [7:0] s = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(no_z)) s = s + flat_pz[8*i +: 8];
      else if (i < int'(no_z + no_p)) s = s - flat_pz[8*i +: 8];
    end
    return s;
  endfunction

  task automatic send(input logic [7:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 50) begin tick(); n++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout data=%h s_ready stuck at 0", d);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic settle_flush();
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 8'd0;
    tick(); tick();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    checks++; if ({acc_ready, acc_valid, hdr_err} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {acc_ready, acc_valid, hdr_err}); end
    checks++; if (flat_pz !== 64'd0 || no_z !== 32'd0 || no_p !== 32'd0) begin errors++; $display("FAIL rst_regs flat=%h nz=%0d np=%0d exp 0", flat_pz, no_z, no_p); end
    rst = 1'b0;
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL idle_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_basic();
    send(8'h12);
    checks++; if (no_z !== 32'd2 || no_p !== 32'd1) begin errors++; $display("FAIL basic_counts nz=%0d np=%0d exp 2 1", no_z, no_p); end
    checks++; if ({s_ready, acc_ready, acc_valid} !== 3'b100) begin errors++; $display("FAIL basic_load_flags got=%b exp=100", {s_ready, acc_ready, acc_valid}); end
    send(8'd10); send(8'd20); send(8'd5);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({s_ready, acc_ready, acc_valid} !== 3'b010) begin
        errors++; $display("FAIL basic_flush_cyc%0d got=%b exp=010", k, {s_ready, acc_ready, acc_valid});
      end
      tick();
    end
    checks++; if ({s_ready, acc_ready, acc_valid} !== 3'b111) begin errors++; $display("FAIL basic_run_flags got=%b exp=111", {s_ready, acc_ready, acc_valid}); end
    checks++; if (flat_pz !== 64'h0000_0000_0005_140A) begin errors++; $display("FAIL basic_flat got=%h exp=%h", flat_pz, 64'h0000_0000_0005_140A); end
    checks++; if (acc_pz() !== 8'd25) begin errors++; $display("FAIL basic_acc got=%0d exp=25", acc_pz()); end
  endtask

  task automatic test_wrap();
    send(8'h04);
    checks++; if ({acc_ready, acc_valid} !== 2'b00) begin errors++; $display("FAIL wrap_drop got=%b exp=00", {acc_ready, acc_valid}); end
    for (int k = 0; k < 4; k++) send(8'd100);
    settle_flush();
    checks++; if (acc_valid !== 1'b1 || acc_pz() !== 8'h90) begin errors++; $display("FAIL wrap_acc valid=%b got=%h exp=90", acc_valid, acc_pz()); end
    send(8'h10); send(8'd1);
    settle_flush();
    checks++; if (acc_valid !== 1'b1 || acc_pz() !== 8'hFF) begin errors++; $display("FAIL neg_acc valid=%b got=%h exp=ff", acc_valid, acc_pz()); end
    checks++; if (flat_pz !== 64'h1) begin errors++; $display("FAIL neg_flat got=%h exp=1", flat_pz); end
  endtask

  task automatic test_illegal();
    // Illegal header in RUN keeps contents and state.
    send(8'h45);
    checks++; if (hdr_err !== 1'b1 || acc_valid !== 1'b1 || flat_pz !== 64'h1 || no_p !== 32'd1) begin
      errors++; $display("FAIL run_illegal err=%b valid=%b flat=%h np=%0d", hdr_err, acc_valid, flat_pz, no_p); end
    rst = 1'b1; tick(); rst = 1'b0; tick();
    send(8'h55);
    checks++; if (hdr_err !== 1'b1) begin errors++; $display("FAIL idle_illegal_pulse got=%b exp=1", hdr_err); end
    checks++; if ({s_ready, acc_ready, acc_valid} !== 3'b100 || flat_pz !== 64'd0 || no_z !== 32'd0) begin
      errors++; $display("FAIL idle_illegal_state flags=%b flat=%h nz=%0d", {s_ready, acc_ready, acc_valid}, flat_pz, no_z); end
    tick();
    checks++; if (hdr_err !== 1'b0) begin errors++; $display("FAIL illegal_pulse_len got=%b exp=0", hdr_err); end
    send(8'h00);
    checks++; if ({s_ready, acc_ready, acc_valid} !== 3'b010) begin errors++; $display("FAIL empty_flush got=%b exp=010", {s_ready, acc_ready, acc_valid}); end
    settle_flush();
    checks++; if (acc_valid !== 1'b1 || acc_pz() !== 8'd0) begin errors++; $display("FAIL empty_acc valid=%b got=%0d exp=0", acc_valid, acc_pz()); end
  endtask

  task automatic test_backpressure();
    send(8'h13);
    s_valid = 1'b1; s_data = 8'd1;  tick();
    s_valid = 1'b0; s_data = 8'd99; tick();
    s_valid = 1'b1; s_data = 8'd2;  tick();
    s_valid = 1'b0; tick(); tick();
    s_valid = 1'b1; s_data = 8'd3;  tick();
    s_data  = 8'd4; tick();
    s_data  = 8'd77;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (s_ready !== 1'b0 || acc_valid !== 1'b0) begin
        errors++; $display("FAIL bp_flush_cyc%0d s_ready=%b valid=%b exp 0 0", k, s_ready, acc_valid);
      end
      tick();
    end
    s_valid = 1'b0;
    checks++; if (acc_valid !== 1'b1 || hdr_err !== 1'b0) begin errors++; $display("FAIL bp_run valid=%b err=%b exp 1 0", acc_valid, hdr_err); end
    checks++; if (flat_pz !== 64'h0000_0000_0403_0201) begin errors++; $display("FAIL bp_flat got=%h exp=04030201", flat_pz); end
    checks++; if (acc_pz() !== 8'd2) begin errors++; $display("FAIL bp_acc got=%0d exp=2", acc_pz()); end
  endtask

  task automatic test_back_to_back();
    // Reload from RUN, then a header that exactly fills the file.
    send(8'h01);
    checks++; if ({acc_ready, acc_valid} !== 2'b00 || flat_pz !== 64'd0 || no_z !== 32'd1 || no_p !== 32'd0) begin
      errors++; $display("FAIL reload_hdr flags=%b flat=%h nz=%0d np=%0d", {acc_ready, acc_valid}, flat_pz, no_z, no_p); end
    send(8'd7);
    settle_flush();
    checks++; if (acc_valid !== 1'b1 || acc_pz() !== 8'd7 || flat_pz !== 64'd7) begin
      errors++; $display("FAIL reload_acc valid=%b acc=%0d flat=%h exp 1 7 7", acc_valid, acc_pz(), flat_pz); end
    send(8'h44);
    for (int k = 1; k <= 8; k++) send(8'(k));
    settle_flush();
    checks++; if (acc_valid !== 1'b1 || flat_pz !== 64'h0807_0605_0403_0201) begin
      errors++; $display("FAIL full_flat valid=%b got=%h exp=0807060504030201", acc_valid, flat_pz); end
    checks++; if (acc_pz() !== 8'hF0) begin errors++; $display("FAIL full_acc got=%h exp=f0", acc_pz()); end
  endtask

  task automatic test_reset_mid_load();
    send(8'h12); send(8'd10);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({s_ready, acc_ready, acc_valid, hdr_err} !== 4'b0000 || flat_pz !== 64'd0 || no_z !== 32'd0 || no_p !== 32'd0) begin
      errors++; $display("FAIL midload_rst flags=%b flat=%h nz=%0d np=%0d", {s_ready, acc_ready, acc_valid, hdr_err}, flat_pz, no_z, no_p); end
    tick();
    checks++; if ({s_ready, acc_ready} !== 2'b10) begin errors++; $display("FAIL midload_idle got=%b exp=10", {s_ready, acc_ready}); end
    send(8'h12); send(8'd10); send(8'd20); send(8'd5);
    settle_flush();
    checks++; if (acc_valid !== 1'b1 || acc_pz() !== 8'd25 || flat_pz !== 64'h0005_140A) begin
      errors++; $display("FAIL midload_reload valid=%b acc=%0d flat=%h", acc_valid, acc_pz(), flat_pz); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
